cache_victim_ctrl: RTL

- Consumer side of the replacement-policy interface inside a set-associative cache.
- Classifies each lookup as hit or miss, and drives `access`/`update` back to the replacement generator (`repl_rand` or a PLRU).
- On a miss it picks a victim way: the first invalid way if one exists, otherwise the policy's `repl_index`.
- Sequences the dirty write-back and the line refill through a small FSM, then reports completion to the cache pipeline.

---
 rtl/cache_victim_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/cache_victim_ctrl.sv
// Miss/hit controller on the consumer side of a cache replacement policy.
// Picks the victim way, then sequences write-back and refill before reporting completion.
module cache_victim_ctrl #(
    parameter int SET_ASSOC   = 4,
    parameter int INDEX_WIDTH = 7,
    localparam int WAY_W      = $clog2(SET_ASSOC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lookup_valid,
    input  logic [INDEX_WIDTH-1:0] lookup_index,
    input  logic [SET_ASSOC-1:0]   hit,
    input  logic [SET_ASSOC-1:0]   way_valid,
    input  logic [SET_ASSOC-1:0]   way_dirty,
    output logic                   lookup_ready,
    input  logic [WAY_W-1:0]       repl_index,
    output logic [SET_ASSOC-1:0]   access,
    output logic                   update,
    output logic                   wb_req,
    output logic [WAY_W-1:0]       wb_way,
    output logic [INDEX_WIDTH-1:0] wb_index,
    input  logic                   wb_ack,
    output logic                   refill_req,
    output logic [WAY_W-1:0]       refill_way,
    output logic [INDEX_WIDTH-1:0] refill_index,
    input  logic                   refill_ack,
    output logic                   done,
    output logic [WAY_W-1:0]       done_way
);

    typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;

    state_t                 state;
    logic [WAY_W-1:0]       victim_way;
    logic [INDEX_WIDTH-1:0] victim_index;
    logic [WAY_W-1:0]       pick_way;
    logic                   pick_dirty;
    logic                   accept_hit;
    logic                   accept_miss;

    // Scan from the top so the lowest invalid way wins; fall back to the policy suggestion.
    always_comb begin
        pick_way = repl_index;
        for (int unsigned i = SET_ASSOC; i > 0; i--) begin
            if (!way_valid[WAY_W'(i - 1)]) pick_way = WAY_W'(i - 1);
        end
        pick_dirty = way_valid[pick_way] & way_dirty[pick_way];
    end

    assign lookup_ready = (state == IDLE) && !rst;
    assign accept_hit   = lookup_ready && lookup_valid && (hit != '0);
    assign accept_miss  = lookup_ready && lookup_valid && (hit == '0);

    always_comb begin
        access = '0;
        if (accept_hit)
            access = hit;
        else if (done)
            access = SET_ASSOC'(1) << victim_way;
    end

    assign update       = accept_hit || done;
    assign wb_way       = victim_way;
    assign wb_index     = victim_index;
    assign refill_way   = victim_way;
    assign refill_index = victim_index;
    assign done_way     = victim_way;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            victim_way   <= '0;
            victim_index <= '0;
            wb_req       <= 1'b0;
            refill_req   <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_miss) begin
                        victim_way   <= pick_way;
                        victim_index <= lookup_index;
                        if (pick_dirty) begin
                            state  <= WB;
                            wb_req <= 1'b1;
                        end else begin
                            state      <= REFILL;
                            refill_req <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (wb_ack) begin
                        state      <= REFILL;
                        wb_req     <= 1'b0;
                        refill_req <= 1'b1;
                    end
                end
                REFILL: begin
                    if (refill_ack) begin
                        state      <= DONE;
                        refill_req <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
